line_window_ctrl: RTL and testbench

Sequencing controller for the two 24-bit line FIFOs, `fifo_generator_0` instances, that form the 3-row pixel window of the image-processing pipeline. It accepts a raster pixel stream handshake and counts column and row positions. It drives the write and read enables of line FIFO 0 (previous row) and line FIFO 1 (row before that), flags when a full 3x3 window is valid, and drains both FIFOs at end of frame so every frame starts from empty FIFOs. Pixel data does not pass through this block: it flows from the source to FIFO 0 `din`, and from FIFO 0 `dout` to FIFO 1 `din`.

---
 rtl/line_window_ctrl_if.sv | 41 ++++
 rtl/line_window_ctrl.sv | 149 ++++++++++++++
 tb/tb_line_window_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_window_ctrl_if.sv
// line_window_ctrl_if
// Bundles the pixel-stream handshake and the line-FIFO control/status
// signals of line_window_ctrl.
//   master : pixel source / pipeline side (drives pix_valid, observes the rest)
//   slave  : line_window_ctrl (accepts pix_valid, drives enables and flags)
// Signals:
//   pix_valid/pix_ready   pixel handshake, accept = pix_valid & pix_ready
//   f0_wr_en/f0_rd_en     FIFO 0 (previous row) enables
//   f1_wr_en/f1_rd_en     FIFO 1 (row before that) enables
//   tap_valid/win_valid   tap alignment and full 3x3 window flags
//   out_col/out_row       coordinates of the pixel accepted one cycle earlier
//   flushing/frame_done   end-of-frame drain status
interface line_window_ctrl_if #(
  parameter int CW = 8,
  parameter int RW = 12
);
  logic          pix_valid;
  logic          pix_ready;
  logic          f0_wr_en;
  logic          f0_rd_en;
  logic          f1_wr_en;
  logic          f1_rd_en;
  logic          tap_valid;
  logic          win_valid;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          flushing;
  logic          frame_done;

  modport master (
    output pix_valid,
    input  pix_ready, f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en,
    input  tap_valid, win_valid, out_col, out_row, flushing, frame_done
  );

  modport slave (
    input  pix_valid,
    output pix_ready, f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en,
    output tap_valid, win_valid, out_col, out_row, flushing, frame_done
  );
endinterface

// File: rtl/line_window_ctrl.sv
// line_window_ctrl
// Sequencing controller for the two line FIFOs forming a 3-row pixel window.
// Counts raster column/row positions of accepted pixels, issues the FIFO
// write/read enables, flags tap and 3x3 window validity, and drains both
// FIFOs for IMG_W cycles at end of frame so each frame starts from empty.
// Pixel data itself never passes through this block.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset (shared with the line FIFOs)
//   bus  line_window_ctrl_if.slave (handshake, FIFO enables, status)
// Parameters:
//   IMG_W  pixels per line (3..255), CW column counter width (2^CW > IMG_W)
//   IMG_H  lines per frame (3..4095), RW row counter width (2^RW > IMG_H)
module line_window_ctrl #(
  parameter int IMG_W = 240,
  parameter int IMG_H = 180,
  parameter int CW    = 8,
  parameter int RW    = 12
) (
  input logic                clk,
  input logic                rst,
  line_window_ctrl_if.slave  bus
);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] DRAIN_PRE = CW'(IMG_W - 2);
  localparam logic [CW-1:0] COL_TWO   = CW'(2);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_TWO   = RW'(2);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] drain;
  logic          ready_q;
  logic          flushing_q;
  logic          done_q;

  logic          acc;
  logic          row_ge1;
  logic          row_ge2;
  logic          col_ge2;

  logic          vld_p1;
  logic          win_vld_p1;
  logic          f1_wr_p1;
  logic [CW-1:0] col_p1;
  logic [RW-1:0] row_p1;

  // ready_q is only high in RUN, so acc can never fire during a drain.
  assign acc     = bus.pix_valid & ready_q;
  assign row_ge1 = (row != '0);
  assign row_ge2 = (row >= ROW_TWO);
  assign col_ge2 = (col >= COL_TWO);

  // Stage p0: enables issued in the cycle of the accept. During FLUSH both
  // FIFOs are read every cycle and nothing is written into FIFO 0.
  assign bus.f0_wr_en = acc;
  assign bus.f0_rd_en = (acc & row_ge1) | flushing_q;
  assign bus.f1_rd_en = (acc & row_ge2) | flushing_q;

  assign bus.pix_ready  = ready_q;
  assign bus.flushing   = flushing_q;
  assign bus.frame_done = done_q;

  // Raster counters, RUN/FLUSH sequencing and the registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      col        <= '0;
      row        <= '0;
      drain      <= '0;
      ready_q    <= 1'b1;
      flushing_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        RUN: begin
          if (acc) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row        <= '0;
                state      <= FLUSH;
                ready_q    <= 1'b0;
                flushing_q <= 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        FLUSH: begin
          // Raised one cycle early so the pulse lands on the last drain cycle.
          if (drain == DRAIN_PRE) begin
            done_q <= 1'b1;
          end
          if (drain == COL_LAST) begin
            drain      <= '0;
            state      <= RUN;
            ready_q    <= 1'b1;
            flushing_q <= 1'b0;
          end else begin
            drain <= drain + 1'b1;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Stage p1: one cycle after the accept FIFO 0 dout holds the value read,
  // which FIFO 1 captures. Only RUN-issued reads are forwarded, because acc
  // is low throughout FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      win_vld_p1 <= 1'b0;
      f1_wr_p1   <= 1'b0;
      col_p1     <= '0;
      row_p1     <= '0;
    end else begin
      vld_p1     <= acc;
      win_vld_p1 <= acc & row_ge2 & col_ge2;
      f1_wr_p1   <= acc & row_ge1;
      if (acc) begin
        col_p1 <= col;
        row_p1 <= row;
      end
    end
  end

  assign bus.tap_valid = vld_p1;
  assign bus.win_valid = win_vld_p1;
  assign bus.f1_wr_en  = f1_wr_p1;
  assign bus.out_col   = col_p1;
  assign bus.out_row   = row_p1;

endmodule

// File: tb/tb_line_window_ctrl.sv
// tb_line_window_ctrl
// Directed bench for line_window_ctrl with IMG_W = IMG_H = 4. Two behavioural
// standard FIFOs stand in for the line FIFOs: FIFO 0 is written with the pixel
// index, FIFO 1 with FIFO 0 dout; dout is valid the cycle after a read.
module tb_line_window_ctrl;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CW = 8;
  localparam int RW = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  line_window_ctrl_if #(.CW(CW), .RW(RW)) bus ();

  line_window_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Line FIFO models
  logic [23:0] f0_mem [256];
  logic [23:0] f1_mem [256];
  logic [23:0] f0_dout, f1_dout;
  int f0_wp, f0_rp, f0_cnt, f1_wp, f1_rp, f1_cnt;
  logic uflow, ovfl;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      f0_wp <= 0; f0_rp <= 0; f0_cnt <= 0; f0_dout <= '0;
      f1_wp <= 0; f1_rp <= 0; f1_cnt <= 0; f1_dout <= '0;
      uflow <= 1'b0; ovfl <= 1'b0;
    end else begin
      if (bus.f0_wr_en) begin
        f0_mem[f0_wp] <= pix_data;
        f0_wp <= (f0_wp + 1) % 256;
      end
      if (bus.f0_rd_en) begin
        if (f0_cnt == 0) uflow <= 1'b1;
        else begin
          f0_dout <= f0_mem[f0_rp];
          f0_rp <= (f0_rp + 1) % 256;
        end
      end
      f0_cnt <= f0_cnt + int'(bus.f0_wr_en) - int'(bus.f0_rd_en && f0_cnt > 0);
      if (bus.f1_wr_en) begin
        f1_mem[f1_wp] <= f0_dout;
        f1_wp <= (f1_wp + 1) % 256;
      end
      if (bus.f1_rd_en) begin
        if (f1_cnt == 0) uflow <= 1'b1;
        else begin
          f1_dout <= f1_mem[f1_rp];
          f1_rp <= (f1_rp + 1) % 256;
        end
      end
      f1_cnt <= f1_cnt + int'(bus.f1_wr_en) - int'(bus.f1_rd_en && f1_cnt > 0);
      if (f0_cnt > W || f1_cnt > W) ovfl <= 1'b1;
    end
  end

  // Observations collected by run_frame
  int f0rd_first, f1rd_first, f1wr_cnt, f1wr_err, coord_err, spurious, idle_en;
  int en_err, ready_low, flush_cnt, done_cnt, done_pos, flush_wr, flush_rd_err;
  int f0_cnt_end, f1_cnt_end, frame_timeout;
  logic [15:0] win_mask, rd0_mask, rd1_mask;
  int win_f0 [16];
  int win_f1 [16];
  logic first_run_wr;
  logic [3:0] bub_pat = 4'b1001;

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // mode 0: continuous, 1: valid pattern 1,0,0,1, 2: valid held high in FLUSH.
  // Returns on the first RUN cycle after the drain (mode 2 accepts a pixel there).
  task automatic run_frame(input int mode);
    int p, c, prev_p;
    logic prev_acc, prev_rd0, acc, done;
    f0rd_first = -1; f1rd_first = -1; f1wr_cnt = 0; f1wr_err = 0; coord_err = 0;
    spurious = 0; idle_en = 0; en_err = 0; ready_low = 0; flush_cnt = 0;
    done_cnt = 0; done_pos = -1; flush_wr = 0; flush_rd_err = 0;
    f0_cnt_end = -1; f1_cnt_end = -1; first_run_wr = 1'b0;
    win_mask = '0; rd0_mask = '0; rd1_mask = '0;
    for (int i = 0; i < 16; i++) begin win_f0[i] = -1; win_f1[i] = -1; end
    p = 0; c = 0; prev_p = 0; prev_acc = 1'b0; prev_rd0 = 1'b0; done = 1'b0;
    while (!done && c < 200) begin
      @(posedge clk); #2;
      if (p < 16) bus.pix_valid = (mode == 1) ? bub_pat[c % 4] : 1'b1;
      else        bus.pix_valid = (mode == 2);
      pix_data = 24'(p);
      #1;
      if (prev_acc) begin
        if (!bus.tap_valid || bus.out_col !== CW'(prev_p % W) || bus.out_row !== RW'(prev_p / W))
          coord_err++;
        if (bus.win_valid && prev_p < 16) begin
          win_mask[prev_p] = 1'b1;
          win_f0[prev_p] = int'(f0_dout);
          win_f1[prev_p] = int'(f1_dout);
        end
      end else if (bus.tap_valid || bus.win_valid) spurious++;
      if (bus.f1_wr_en) f1wr_cnt++;
      if (bus.f1_wr_en !== prev_rd0) f1wr_err++;
      acc = bus.pix_valid & bus.pix_ready;
      if (p >= 16) begin
        if (!bus.pix_ready) ready_low++;
        if (bus.flushing) begin
          flush_cnt++;
          if (bus.f0_wr_en) flush_wr++;
          if (!(bus.f0_rd_en && bus.f1_rd_en)) flush_rd_err++;
        end
        if (bus.frame_done) begin
          done_cnt++;
          done_pos = bus.flushing ? flush_cnt : -1;
        end
        if (bus.pix_ready && ready_low > 0) begin
          done = 1'b1;
          first_run_wr = bus.f0_wr_en;
          f0_cnt_end = f0_cnt;
          f1_cnt_end = f1_cnt;
        end
      end
      if (acc) begin
        if (p < 16) begin
          rd0_mask[p] = bus.f0_rd_en;
          rd1_mask[p] = bus.f1_rd_en;
          if (!bus.f0_wr_en) en_err++;
          if (bus.f0_rd_en && f0rd_first < 0) f0rd_first = p;
          if (bus.f1_rd_en && f1rd_first < 0) f1rd_first = p;
        end
      end else if (!bus.flushing && (bus.f0_wr_en || bus.f0_rd_en || bus.f1_rd_en)) idle_en++;
      prev_rd0 = acc & bus.f0_rd_en;
      prev_acc = acc;
      prev_p = p;
      if (acc) p++;
      c++;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL frame_timeout: mode %0d got %0d accepts in %0d cycles, required frame end", mode, p, c);
    end
  endtask

  task automatic test_reset();
    logic [8:0] flags;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #2;
      bus.pix_valid = 1'b1;
      pix_data = 24'(i);
    end
    @(posedge clk); #2;
    bus.pix_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.out_row !== RW'(2)) begin n_errors++;
      $display("FAIL pre_reset_row: got %0d required 2", bus.out_row); end
    rst = 1'b1;
    #1;
    flags = {bus.pix_ready, bus.f0_wr_en, bus.f0_rd_en, bus.f1_wr_en, bus.f1_rd_en,
             bus.tap_valid, bus.win_valid, bus.flushing, bus.frame_done};
    n_checks++;
    if (flags !== 9'b1_0000_0000) begin n_errors++;
      $display("FAIL reset_flags: got %b required 100000000", flags); end
    n_checks++;
    if (bus.out_col !== '0 || bus.out_row !== '0) begin n_errors++;
      $display("FAIL reset_coords: got col %0d row %0d required 0 0", bus.out_col, bus.out_row); end
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.pix_ready !== 1'b1) begin n_errors++;
      $display("FAIL ready_after_reset: got %b required 1", bus.pix_ready); end
    #1;
    bus.pix_valid = 1'b1;
    pix_data = 24'd0;
    #1;
    n_checks++;
    if (bus.f0_wr_en !== 1'b1 || bus.f0_rd_en !== 1'b0 || bus.f1_rd_en !== 1'b0) begin n_errors++;
      $display("FAIL first_pixel_en: got wr %b rd0 %b rd1 %b required 1 0 0",
               bus.f0_wr_en, bus.f0_rd_en, bus.f1_rd_en); end
    @(posedge clk); #2;
    bus.pix_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.tap_valid !== 1'b1 || bus.out_col !== '0 || bus.out_row !== '0) begin n_errors++;
      $display("FAIL first_pixel_coord: got tap %b col %0d row %0d required 1 0 0",
               bus.tap_valid, bus.out_col, bus.out_row); end
  endtask

  task automatic test_continuous();
    do_reset();
    run_frame(0);
    n_checks++;
    if (f0rd_first != 4 || f1rd_first != 8) begin n_errors++;
      $display("FAIL first_reads: got f0 %0d f1 %0d required 4 8", f0rd_first, f1rd_first); end
    n_checks++;
    if (rd0_mask !== 16'hFFF0 || rd1_mask !== 16'hFF00) begin n_errors++;
      $display("FAIL read_masks: got %h %h required fff0 ff00", rd0_mask, rd1_mask); end
    n_checks++;
    if (f1wr_cnt != 12 || f1wr_err != 0) begin n_errors++;
      $display("FAIL f1_wr: got count %0d misaligned %0d required 12 0", f1wr_cnt, f1wr_err); end
    n_checks++;
    if (win_mask !== 16'hCC00) begin n_errors++;
      $display("FAIL win_mask: got %h required cc00", win_mask); end
    n_checks++;
    if (coord_err != 0 || spurious != 0 || en_err != 0) begin n_errors++;
      $display("FAIL cont_taps: got coord %0d spurious %0d wr %0d required 0 0 0",
               coord_err, spurious, en_err); end
  endtask

  task automatic test_alignment();
    int pix [4];
    pix = '{10, 11, 14, 15};
    do_reset();
    run_frame(0);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (win_f0[pix[k]] != pix[k] - 4 || win_f1[pix[k]] != pix[k] - 8) begin n_errors++;
        $display("FAIL align_px%0d: got f0 %0d f1 %0d required %0d %0d",
                 pix[k], win_f0[pix[k]], win_f1[pix[k]], pix[k] - 4, pix[k] - 8); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    run_frame(0);
    n_checks++;
    if (ready_low != W || flush_cnt != W || flush_rd_err != 0) begin n_errors++;
      $display("FAIL flush_len: got ready_low %0d flushing %0d rd_err %0d required 4 4 0",
               ready_low, flush_cnt, flush_rd_err); end
    n_checks++;
    if (done_cnt != 1 || done_pos != W) begin n_errors++;
      $display("FAIL frame_done: got pulses %0d at flush cycle %0d required 1 4", done_cnt, done_pos); end
    n_checks++;
    if (f0_cnt_end != 0 || f1_cnt_end != 0) begin n_errors++;
      $display("FAIL fifo_empty: got %0d %0d required 0 0", f0_cnt_end, f1_cnt_end); end
    run_frame(0);
    n_checks++;
    if (f0rd_first != 4 || f1rd_first != 8 || f1wr_cnt != 12 || win_mask !== 16'hCC00) begin n_errors++;
      $display("FAIL second_frame: got f0 %0d f1 %0d f1wr %0d win %h required 4 8 12 cc00",
               f0rd_first, f1rd_first, f1wr_cnt, win_mask); end
    n_checks++;
    if (uflow !== 1'b0 || ovfl !== 1'b0) begin n_errors++;
      $display("FAIL fifo_bounds: got underflow %b overflow %b required 0 0", uflow, ovfl); end
  endtask

  task automatic test_bubbles();
    do_reset();
    run_frame(1);
    n_checks++;
    if (win_mask !== 16'hCC00) begin n_errors++;
      $display("FAIL bub_win_mask: got %h required cc00", win_mask); end
    n_checks++;
    if (win_f0[10] != 6 || win_f1[10] != 2 || win_f0[15] != 11 || win_f1[15] != 7) begin n_errors++;
      $display("FAIL bub_align: got %0d %0d %0d %0d required 6 2 11 7",
               win_f0[10], win_f1[10], win_f0[15], win_f1[15]); end
    n_checks++;
    if (idle_en != 0 || spurious != 0) begin n_errors++;
      $display("FAIL bub_idle: got idle_en %0d spurious %0d required 0 0", idle_en, spurious); end
    n_checks++;
    if (f1wr_cnt != 12 || f1wr_err != 0 || coord_err != 0) begin n_errors++;
      $display("FAIL bub_f1wr: got count %0d misaligned %0d coord %0d required 12 0 0",
               f1wr_cnt, f1wr_err, coord_err); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    run_frame(2);
    n_checks++;
    if (flush_wr != 0 || ready_low != W) begin n_errors++;
      $display("FAIL bp_flush: got wr %0d ready_low %0d required 0 4", flush_wr, ready_low); end
    n_checks++;
    if (first_run_wr !== 1'b1) begin n_errors++;
      $display("FAIL bp_first_accept: got %b required 1", first_run_wr); end
    @(posedge clk); #2;
    bus.pix_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.tap_valid !== 1'b1 || bus.out_row !== '0 || bus.out_col !== '0) begin n_errors++;
      $display("FAIL bp_next_frame: got tap %b col %0d row %0d required 1 0 0",
               bus.tap_valid, bus.out_col, bus.out_row); end
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    test_reset();
    test_continuous();
    test_alignment();
    test_flush();
    test_bubbles();
    test_back_pressure();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, required finish");
    $fatal(1, "watchdog expired");
  end
endmodule
